// File: rtl/instruction_ci_lwsp_if.sv
// Signal bundle for the c.lwsp load unit: the instruction issue side,
// the register-file read/write ports and the word-addressed RAM port.
interface instruction_ci_lwsp_if;
  // instruction issue
  logic        iVALID;
  logic [15:0] iIR;

  // register file: sp read, rd write-back
  logic [31:0] iRS1;
  logic [4:0]  oRS1;
  logic [4:0]  oRD;
  logic [31:0] oRD_DATA;
  logic        oRD_WE;

  // RAM port
  logic        oRAM_CE;
  logic        oRAM_RD;
  logic        oRAM_WR;
  logic [7:0]  oRAM_ADDR;
  logic [31:0] iRAM_DATA;
  logic        iRAM_ACK;

  // status
  logic        oBUSY;
  logic        oDONE;
  logic        oERR;

  // the load unit itself
  modport slave (
    input  iVALID, iIR, iRS1, iRAM_DATA, iRAM_ACK,
    output oRS1, oRD, oRD_DATA, oRD_WE,
           oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR,
           oBUSY, oDONE, oERR
  );

  // the issuer / environment around the load unit
  modport master (
    output iVALID, iIR, iRS1, iRAM_DATA, iRAM_ACK,
    input  oRS1, oRD, oRD_DATA, oRD_WE,
           oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR,
           oBUSY, oDONE, oERR
  );
endinterface

// File: rtl/instruction_ci_lwsp.sv
// c.lwsp execution unit: decodes the compressed load-word-from-sp,
// forms sp + offset, performs one RAM word read with an ack timeout and
// writes the result back to rd.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a valid c.lwsp; illegal / misaligned -> oERR
//   REQ   | first strobe cycle, ack not yet looked at
//   WAIT  | strobes held, waiting for ack, timeout counter running
//   WB    | one-cycle register write-back with oDONE
module instruction_ci_lwsp #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  instruction_ci_lwsp_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [7:0] TMO_W = 8'(TIMEOUT);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  addr_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic        strobe_q;
  logic        we_q;
  logic        done_q;
  logic        err_q;

  // decode fields of the incoming instruction
  logic        lwsp_hit;
  logic [4:0]  rd_field;
  logic [7:0]  offset;
  logic [31:0] byte_addr;
  logic [7:0]  cnt_d;
  logic        unused_addr_hi;

  assign lwsp_hit  = (bus.iIR[1:0] == 2'b10) && (bus.iIR[15:13] == 3'b010);
  assign rd_field  = bus.iIR[11:7];
  assign offset    = {bus.iIR[3:2], bus.iIR[12], bus.iIR[6:4], 2'b00};
  // full 32-bit sum so wrap-around is modulo 2^32; only [9:0] leave the block
  assign byte_addr = bus.iRS1 + {24'd0, offset};
  assign unused_addr_hi = ^byte_addr[31:10];
  assign cnt_d     = cnt_q + 8'd1;

  // single-process FSM with registered outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 8'd0;
      rd_q     <= 5'd0;
      data_q   <= 32'd0;
      strobe_q <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          strobe_q <= 1'b0;
          if (bus.iVALID && lwsp_hit) begin
            if ((rd_field == 5'd0) || (byte_addr[1:0] != 2'b00)) begin
              err_q <= 1'b1;
            end else begin
              rd_q     <= rd_field;
              addr_q   <= byte_addr[9:2];
              strobe_q <= 1'b1;
              state_q  <= REQ;
            end
          end
        end
        REQ: begin
          cnt_q   <= 8'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          // ack is checked first so it wins over a coincident timeout
          if (bus.iRAM_ACK) begin
            data_q   <= bus.iRAM_DATA;
            strobe_q <= 1'b0;
            we_q     <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= WB;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == TMO_W) begin
              strobe_q <= 1'b0;
              err_q    <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
        WB: begin
          state_q <= IDLE;
        end
        default: begin
          strobe_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.oRS1      = 5'h2;
  assign bus.oRAM_CE   = strobe_q;
  assign bus.oRAM_RD   = strobe_q;
  assign bus.oRAM_WR   = 1'b0;
  assign bus.oRAM_ADDR = addr_q;
  assign bus.oRD       = rd_q;
  assign bus.oRD_DATA  = data_q;
  assign bus.oRD_WE    = we_q;
  assign bus.oDONE     = done_q;
  assign bus.oERR      = err_q;
  assign bus.oBUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_instruction_ci_lwsp.sv
// Scoreboard bench for instruction_ci_lwsp: the driver predicts each
// load's outcome from the instruction rules and queues it; the monitor
// checks every cycle and pops on each write-back or error pulse.
module tb_instruction_ci_lwsp;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  instruction_ci_lwsp_if bus ();

  instruction_ci_lwsp #(.TIMEOUT(TMO)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [7:0]  addr;
    int          lat;
    int          strobes;
    int          t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   strobe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // outcome of one issued instruction, from the architectural rules
  function automatic exp_t model(input logic [15:0] ir, input logic [31:0] rs1,
                                 input int d, input logic [31:0] data, input int t0,
                                 output bit active);
    exp_t        e;
    int          off;
    logic [31:0] a;
    active    = (ir[1:0] == 2'b10) && (ir[15:13] == 3'b010);
    off       = ir[6:4] * 4 + ir[12] * 32 + ir[3:2] * 64;
    a         = rs1 + off;
    e.rd      = ir[11:7];
    e.addr    = a[9:2];
    e.t0      = t0;
    e.data    = data;
    if (e.rd == 5'd0 || (a % 4) != 0) begin
      e.is_err = 1'b1; e.lat = 1; e.strobes = 0;
    end else if (d >= TMO) begin
      e.is_err = 1'b1; e.lat = TMO + 2; e.strobes = TMO + 1;
    end else begin
      e.is_err = 1'b0; e.lat = 3 + d; e.strobes = 2 + d;
    end
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_ce"},      bus.oRAM_CE,   0);
    check({tag, "_rd"},      bus.oRAM_RD,   0);
    check({tag, "_wr"},      bus.oRAM_WR,   0);
    check({tag, "_addr"},    bus.oRAM_ADDR, 0);
    check({tag, "_rdidx"},   bus.oRD,       0);
    check({tag, "_rddata"},  bus.oRD_DATA,  0);
    check({tag, "_we"},      bus.oRD_WE,    0);
    check({tag, "_busy"},    bus.oBUSY,     0);
    check({tag, "_done"},    bus.oDONE,     0);
    check({tag, "_err"},     bus.oERR,      0);
  endtask

  // leaves the caller #1 after a posedge with oBUSY low
  task automatic wait_idle();
    int n = 0;
    while (bus.oBUSY && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.oBUSY) check("idle_wait_timeout", bus.oBUSY, 0);
  endtask

  // d = ack delay in WAIT cycles (>= TMO means never ack)
  task automatic load(input logic [15:0] ir, input logic [31:0] rs1, input int d,
                      input logic [31:0] data, input bit junk_req_ack, input bit poke);
    exp_t e;
    bit   active;
    wait_idle();
    bus.iVALID = 1'b1;
    bus.iIR    = ir;
    bus.iRS1   = rs1;
    e = model(ir, rs1, d, data, cyc, active);
    if (active) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.iVALID = 1'b0;
    bus.iIR    = 16'($urandom);
    bus.iRS1   = $urandom;
    if (!active || e.strobes == 0) return;
    // REQ cycle: ack here must be ignored
    if (junk_req_ack) begin
      bus.iRAM_ACK  = 1'b1;
      bus.iRAM_DATA = $urandom;
    end
    @(posedge clk); #1;
    bus.iRAM_ACK = 1'b0;
    // first WAIT cycle: a fresh request while busy must be ignored
    if (poke) begin
      bus.iVALID = 1'b1;
      bus.iIR    = 16'h4512;
      bus.iRS1   = 32'h100;
    end
    if (d < TMO) begin
      for (int k = 0; k < d; k++) begin
        @(posedge clk); #1;
        bus.iVALID = 1'b0;
      end
      bus.iRAM_ACK  = 1'b1;
      bus.iRAM_DATA = data;
      @(posedge clk); #1;
      bus.iRAM_ACK  = 1'b0;
      bus.iVALID    = 1'b0;
      bus.iRAM_DATA = $urandom;
    end else begin
      @(posedge clk); #1;
      bus.iVALID = 1'b0;
    end
  endtask

  task automatic reset_mid_wait();
    exp_t e;
    bit   active;
    wait_idle();
    bus.iVALID = 1'b1;
    bus.iIR    = 16'h4512;
    bus.iRS1   = 32'h100;
    e = model(16'h4512, 32'h100, 0, 0, cyc, active);
    exp_q.push_back(e);
    @(posedge clk); #1;                 // REQ
    bus.iVALID = 1'b0;
    @(posedge clk); #1;                 // WAIT 1st
    @(posedge clk); #1;                 // WAIT 2nd
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_vals("rst_mid_wait");
    bus.iRAM_ACK  = 1'b1;               // late ack after reset
    bus.iRAM_DATA = 32'hBAD0BAD0;
    repeat (2) begin @(posedge clk); #1; end
    bus.iRAM_ACK = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("late_ack_busy", bus.oBUSY, 0);
    check("late_ack_rddata", bus.oRD_DATA, 0);
  endtask

  // monitor: per-cycle invariants plus scoreboard pop on each pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        strobe_cnt = 0;
        continue;
      end
      check("ram_wr_zero", bus.oRAM_WR, 0);
      check("rs1_index",   bus.oRS1, 5'h2);
      check("ce_eq_rd",    bus.oRAM_CE, bus.oRAM_RD);
      check("done_eq_we",  bus.oDONE, bus.oRD_WE);
      check("err_excl_we", bus.oERR & bus.oRD_WE, 0);
      if (bus.oRAM_RD) begin
        strobe_cnt++;
        check("ram_access_expected", (exp_q.size() > 0) && (exp_q[0].strobes > 0), 1);
        if (exp_q.size() > 0) check("ram_addr", bus.oRAM_ADDR, exp_q[0].addr);
      end
      if (bus.oRD_WE || bus.oERR) begin
        check("pulse_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("outcome_err",   bus.oERR, e.is_err);
          check("latency",       cyc - e.t0, e.lat);
          check("strobe_cycles", strobe_cnt, e.strobes);
          check("busy_at_pulse", bus.oBUSY, !e.is_err);
          if (!e.is_err) begin
            check("wb_rd",   bus.oRD, e.rd);
            check("wb_data", bus.oRD_DATA, e.data);
          end
        end
        strobe_cnt = 0;
      end
    end
  end

  // stimulus
  initial begin
    logic [15:0] ir;
    logic [31:0] rs1;
    int          d;
    bus.iVALID    = 1'b0;
    bus.iIR       = 16'd0;
    bus.iRS1      = 32'd0;
    bus.iRAM_DATA = 32'd0;
    bus.iRAM_ACK  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    load(16'h4512, 32'h0000_0100, 0,       32'hDEADBEEF, 1'b0, 1'b0);
    load(16'h4512, 32'h0000_0100, 5,       32'hDEADBEEF, 1'b0, 1'b0);
    load(16'h4512, 32'h0000_0100, TMO,     32'h0,        1'b0, 1'b0);
    load(16'h4512, 32'h0000_0100, TMO - 1, 32'h12345678, 1'b1, 1'b1);
    load(16'h4002, 32'h0000_0100, 0,       32'h0,        1'b0, 1'b0);
    load(16'h4512, 32'h0000_0102, 0,       32'h0,        1'b0, 1'b0);
    load(16'h4522, 32'hFFFF_FFFC, 0,       32'hCAFEF00D, 1'b0, 1'b0);
    load(16'h0001, 32'h0000_0100, 0,       32'h0,        1'b0, 1'b0);
    load(16'h5512, 32'h0000_0100, 0,       32'h0,        1'b0, 1'b0);
    reset_mid_wait();
    load(16'h4512, 32'h0000_0100, 1,       32'h0BADF00D, 1'b1, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) ir = 16'($urandom);
      else ir = {3'b010, 1'($urandom), 5'($urandom), 3'($urandom), 2'($urandom), 2'b10};
      rs1 = $urandom;
      if ($urandom_range(0, 7) != 0) rs1[1:0] = 2'b00;
      case ($urandom_range(0, 9))
        0:       d = TMO;
        1:       d = TMO - 1;
        default: d = $urandom_range(0, 6);
      endcase
      load(ir, rs1, d, $urandom, 1'($urandom), 1'($urandom));
    end

    wait_idle();
    repeat (4) begin @(posedge clk); #1; end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_ci_lwsp.md
INSTRUCTION_CI_LWSP -- requirements
Module: instruction_ci_lwsp

Interface
REQ-001 Parameter TIMEOUT, default 15, is the maximum number of cycles spent in WAIT without iRAM_ACK before the load aborts; legal range is 1..255.
REQ-002 iCLK  input  1  is the single clock; all state changes on the rising edge.
REQ-003 iRST  input  1  is the reset; it is synchronous and active-high.
REQ-004 iVALID  input  1  means iIR holds a new compressed instruction this cycle.
REQ-005 iIR  input  16  is the compressed instruction word.
REQ-006 iRS1  input  32  is the register-file read value of oRS1 (sp).
REQ-007 oRS1  output  5  is the register-file read index, constant 5'h2 (sp).
REQ-008 oRAM_CE  output  1  is the RAM chip enable.
REQ-009 oRAM_RD  output  1  is the RAM read strobe.
REQ-010 oRAM_WR  output  1  is the RAM write strobe, constant 0.
REQ-011 oRAM_ADDR  output  8  is the RAM word address.
REQ-012 iRAM_DATA  input  32  is the RAM read data, valid when iRAM_ACK=1.
REQ-013 iRAM_ACK  input  1  means the RAM read has completed.
REQ-014 oRD  output  5  is the destination register index.
REQ-015 oRD_DATA  output  32  is the write-back data.
REQ-016 oRD_WE  output  1  is the register-file write enable.
REQ-017 oBUSY  output  1  is high whenever the FSM is not in IDLE.
REQ-018 oDONE  output  1  is a one-cycle pulse on successful write-back.
REQ-019 oERR  output  1  is a one-cycle pulse on an illegal, misaligned or timed-out load.

Function
REQ-020 Decode c.lwsp when iIR[1:0]=2'b10 and iIR[15:13]=3'b010; any other iIR is ignored with no output activity.
REQ-021 Offset SHALL be zero-extended {iIR[3:2], iIR[12], iIR[6:4], 2'b00}, 8 bits, range 0..252.
REQ-022 Byte address SHALL be iRS1 + offset, computed in 32 bits with wrap-around modulo 2^32.
REQ-023 oRAM_ADDR SHALL be byte address bits [9:2], latched at acceptance and held stable until return to IDLE.
REQ-024 The FSM SHALL have the states IDLE, REQ, WAIT and WB.
REQ-025 IDLE: on iVALID with a decoded c.lwsp, rd=iIR[11:7]≠0 and address[1:0]=0, latch rd and the address and go to REQ.
REQ-026 IDLE: on iVALID with a decoded c.lwsp and rd=0 (reserved encoding), pulse oERR the next cycle and stay in IDLE.
REQ-027 IDLE: on iVALID with a decoded c.lwsp and address[1:0]≠0, pulse oERR the next cycle and stay in IDLE.
REQ-028 REQ: assert oRAM_CE=oRAM_RD=1 for exactly one cycle, then go to WAIT; iRAM_ACK is ignored in REQ.
REQ-029 WAIT: hold oRAM_CE=oRAM_RD=1; on iRAM_ACK, latch iRAM_DATA and go to WB.
REQ-030 WAIT: an 8-bit counter SHALL clear on entry and increment each WAIT cycle without ack.
REQ-031 WAIT timeout: when the counter reaches TIMEOUT without ack, drop the RAM strobes, pulse oERR and go to IDLE, with no register write.
REQ-032 Ack and timeout in the same cycle: the ack wins.
REQ-033 WB: assert oRD_WE=1, oDONE=1 and oRD_DATA=the latched data for one cycle, then go to IDLE.
REQ-034 Latency from accepting iVALID to oRD_WE SHALL be 3 cycles when ack arrives in the first WAIT cycle, plus one cycle per ack delay cycle.
REQ-035 iVALID while oBUSY=1 SHALL be ignored; the issuer must hold off until oBUSY=0.
REQ-036 iVALID arriving in the same cycle the FSM returns to IDLE SHALL be accepted.
REQ-037 oRAM_CE and oRAM_RD SHALL be 0 in IDLE and WB.
REQ-038 oRD_WE, oDONE and oERR SHALL never be high in the same cycle as each other, except oRD_WE with oDONE.

Reset
REQ-039 When iRST=1 at a clock edge, the state goes to IDLE and the counter clears to 0.
REQ-040 Reset values: oRAM_CE=oRAM_RD=oRAM_WR=0, oRAM_ADDR=0, oRD=0, oRD_DATA=0, oRD_WE=0, oBUSY=0, oDONE=0, oERR=0.
REQ-041 Reset in any state, including mid-WAIT, aborts the load with no write-back and no oERR.
REQ-042 A late iRAM_ACK arriving after reset SHALL be ignored.

Verification
REQ-043 iRS1=0x100, iIR=0x4512 (c.lwsp x10, offset 4) with ack in the first WAIT cycle and iRAM_DATA=0xDEADBEEF -> oRAM_ADDR=0x41; oRD=10, oRD_DATA=0xDEADBEEF and oRD_WE pulses 3 cycles after acceptance.
REQ-044 Same load with ack delayed 5 cycles -> oRAM_RD stays high throughout WAIT; write-back occurs at cycle 8; oDONE is a single pulse.
REQ-045 TIMEOUT=15 with no ack -> oERR pulses after 15 WAIT cycles; oRD_WE stays 0; oBUSY=0 the next cycle.
REQ-046 iIR=0x4002 (rd=0) -> oERR pulse only; no RAM strobes.
REQ-047 iRS1=0x102 -> oERR pulse and no RAM access; iRS1=0xFFFFFFFC with offset 8 -> address wraps to 0x4 and oRAM_ADDR=0x01.
REQ-048 iRST asserted in the 2nd WAIT cycle, then ack -> all outputs return to reset values; no oRD_WE and no oERR.
